// File: rtl/nn_layer_par.sv
// Fully-connected layer y = act(W*x + b) with runtime-loadable W/b and P parallel MAC lanes.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   cfg_wr_en/cfg_addr/cfg_data  : weight/bias write port (W[i][j] at i*N+j, b[i] at M*N+i)
//   cfg_ready                    : config writes accepted this cycle
//   s_valid/s_ready/data_in      : input vector stream, x[0] first
//   m_valid/m_ready/data_out     : output vector stream, y[0] first
//   sat                          : data_out was saturated before activation
module nn_layer_par #(
  parameter int unsigned M    = 4,
  parameter int unsigned N    = 5,
  parameter int unsigned P    = 2,
  parameter int unsigned T    = 16,
  parameter int unsigned RELU = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_wr_en,
  input  logic [$clog2(M*N+M)-1:0]    cfg_addr,
  input  logic [T-1:0]                cfg_data,
  output logic                        cfg_ready,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [T-1:0]                data_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [T-1:0]                data_out,
  output logic                        sat
);

  localparam int unsigned ENTRIES = M*N + M;
  localparam int unsigned ADDR_W  = $clog2(ENTRIES);
  localparam int unsigned G       = M / P;
  localparam int unsigned ACCW    = 2*T + $clog2(N) + 1;
  localparam int unsigned XW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW      = $clog2(N + 3);
  localparam int unsigned PW      = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned GW      = (G > 1) ? $clog2(G) : 1;

  if ((M % P) != 0) begin : g_p_check
    $error("nn_layer_par: P must divide M");
  end

  typedef enum logic [1:0] {GET_X, COMPUTE, OUTPUT} state_e;

  state_e state_q, state_d;

  logic signed [T-1:0]    mem_q [ENTRIES];
  logic signed [T-1:0]    x_q   [N];
  logic [XW-1:0]          xcnt_q;
  logic [CW-1:0]          ccnt_q;
  logic [GW-1:0]          g_q;
  logic [PW-1:0]          optr_q;
  logic signed [T-1:0]    w_rd_q [P];
  logic signed [T-1:0]    x_rd_q;
  logic                   rd_vld_q, prod_vld_q;
  logic signed [2*T-1:0]  prod_q [P];
  logic signed [ACCW-1:0] acc_q  [P];
  logic [T-1:0]           obuf_q [P];
  logic [P-1:0]           osat_q;
  logic [T-1:0]           data_out_q;
  logic                   sat_q;

  logic                   s_ready_c, cfg_ready_c, m_valid_c;
  logic                   x_acc, x_last, comp_done, o_acc, o_last, g_last;
  logic [31:0]            col_c;
  logic [ADDR_W-1:0]      w_addr [P];
  logic [ADDR_W-1:0]      b_addr [P];
  logic [T-1:0]           res_c  [P];
  logic [P-1:0]           rsat_c;

  assign x_acc     = s_valid && s_ready_c;
  assign x_last    = x_acc && (xcnt_q == XW'(N-1));
  assign comp_done = (state_q == COMPUTE) && (ccnt_q == CW'(N+2));
  assign o_acc     = m_valid_c && m_ready;
  assign o_last    = o_acc && (optr_q == PW'(P-1));
  assign g_last    = (g_q == GW'(G-1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= GET_X;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GET_X:   if (x_last)    state_d = COMPUTE;
      COMPUTE: if (comp_done) state_d = OUTPUT;
      OUTPUT:  if (o_last)    state_d = g_last ? GET_X : COMPUTE;
      default:                state_d = GET_X;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    s_ready_c   = 1'b0;
    cfg_ready_c = 1'b0;
    m_valid_c   = 1'b0;
    unique case (state_q)
      GET_X: begin
        s_ready_c   = !reset;
        cfg_ready_c = (xcnt_q == '0);
      end
      OUTPUT:  m_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign s_ready   = s_ready_c;
  assign cfg_ready = cfg_ready_c;
  assign m_valid   = m_valid_c;
  assign data_out  = data_out_q;
  assign sat       = sat_q;

  // Read addresses; the column is clamped so addresses stay in range after the last read
  always_comb begin
    col_c = (ccnt_q < CW'(N)) ? 32'(ccnt_q) : 32'd0;
    for (int l = 0; l < P; l++) begin
      w_addr[l] = ADDR_W'((32'(g_q) * P + 32'(l)) * N + col_c);
      b_addr[l] = ADDR_W'(M*N + 32'(g_q) * P + 32'(l));
    end
  end

  // Saturate to T bits (fits when all bits above T-2 agree), then optional ReLU
  always_comb begin
    for (int l = 0; l < P; l++) begin
      res_c[l]  = acc_q[l][T-1:0];
      rsat_c[l] = 1'b0;
      if (!((&acc_q[l][ACCW-1:T-1]) || (~|acc_q[l][ACCW-1:T-1]))) begin
        rsat_c[l] = 1'b1;
        res_c[l]  = acc_q[l][ACCW-1] ? {1'b1, {(T-1){1'b0}}} : {1'b0, {(T-1){1'b1}}};
      end
      if ((RELU != 0) && res_c[l][T-1]) res_c[l] = '0;
    end
  end

  // Weight/bias storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (cfg_wr_en && cfg_ready_c && ({1'b0, cfg_addr} < (ADDR_W+1)'(ENTRIES)))
      mem_q[cfg_addr] <= cfg_data;
  end

  // Control counters and registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      xcnt_q     <= '0;
      ccnt_q     <= '0;
      g_q        <= '0;
      optr_q     <= '0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      data_out_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      if (x_acc) xcnt_q <= x_last ? '0 : xcnt_q + XW'(1);
      if (x_last) g_q <= '0;
      if (state_q == COMPUTE) ccnt_q <= comp_done ? '0 : ccnt_q + CW'(1);
      else                    ccnt_q <= '0;
      rd_vld_q   <= (state_q == COMPUTE) && (ccnt_q < CW'(N));
      prod_vld_q <= rd_vld_q;
      if (comp_done) begin
        optr_q     <= '0;
        data_out_q <= res_c[0];
        sat_q      <= rsat_c[0];
      end
      if (o_acc) begin
        if (o_last) begin
          optr_q <= '0;
          if (!g_last) g_q <= g_q + GW'(1);
        end else begin
          optr_q     <= optr_q + PW'(1);
          data_out_q <= obuf_q[optr_q + PW'(1)];
          sat_q      <= osat_q[optr_q + PW'(1)];
        end
      end
    end
  end

  // MAC pipeline: read -> registered product -> accumulate (bias preloads the accumulator)
  always_ff @(posedge clk) begin
    if (x_acc) x_q[xcnt_q] <= data_in;
    x_rd_q <= x_q[XW'(col_c)];
    for (int l = 0; l < P; l++) begin
      w_rd_q[l] <= mem_q[w_addr[l]];
      prod_q[l] <= (2*T)'(w_rd_q[l]) * (2*T)'(x_rd_q);
      if ((state_q == COMPUTE) && (ccnt_q == '0)) acc_q[l] <= ACCW'(mem_q[b_addr[l]]);
      else if (prod_vld_q)                        acc_q[l] <= acc_q[l] + ACCW'(prod_q[l]);
    end
    if (comp_done) begin
      for (int l = 0; l < P; l++) obuf_q[l] <= res_c[l];
      osat_q <= rsat_c;
    end
  end

endmodule

// File: tb/tb_nn_layer_par.sv
// Directed bench for nn_layer_par: one ReLU instance and one identity instance share stimulus.
module tb_nn_layer_par;

  localparam int M = 4;
  localparam int N = 5;
  localparam int P = 2;
  localparam int T = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_wr_en;
  logic [4:0]    cfg_addr;
  logic [T-1:0]  cfg_data;
  logic          s_valid;
  logic [T-1:0]  data_in;
  logic          m_ready;

  logic          cfg_ready1, s_ready1, m_valid1, sat1;
  logic [T-1:0]  data_out1;
  logic          cfg_ready0, s_ready0, m_valid0, sat0;
  logic [T-1:0]  data_out0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc, first_mv;

  logic [T-1:0] y1 [M];
  logic [T-1:0] y0 [M];
  logic         s1 [M];
  logic         s0 [M];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_layer_par #(.M(M), .N(N), .P(P), .T(T), .RELU(1)) u_dut (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready1), .s_valid(s_valid), .s_ready(s_ready1),
    .data_in(data_in), .m_valid(m_valid1), .m_ready(m_ready), .data_out(data_out1), .sat(sat1)
  );

  nn_layer_par #(.M(M), .N(N), .P(P), .T(T), .RELU(0)) u_dut0 (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready0), .s_valid(s_valid), .s_ready(s_ready0),
    .data_in(data_in), .m_valid(m_valid0), .m_ready(m_ready), .data_out(data_out0), .sat(sat0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input int addr, input logic [T-1:0] val);
    int n = 0;
    while (!cfg_ready1 && n < 200) begin step(); n++; end
    chk("cfg_ready_wait", 32'(cfg_ready1), 32'd1);
    cfg_addr  = 5'(addr);
    cfg_data  = val;
    cfg_wr_en = 1'b1;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic push_words(input logic [T-1:0] xv [N], input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int n = 0;
      data_in = xv[i];
      s_valid = 1'b1;
      while (!s_ready1 && n < 200) begin step(); n++; end
      if (!s_ready1) chk("s_ready_wait", 32'(s_ready1), 32'd1);
      acc_cyc = cyc;
      step();
      s_valid = 1'b0;
    end
  endtask

  // mode 0: m_ready held high; mode 1: random m_ready
  task automatic drain(input int mode);
    int k = 0;
    int n = 0;
    first_mv = -1;
    while (k < M && n < 500) begin
      m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_valid1 && first_mv < 0) first_mv = cyc;
      if (m_valid1 && m_ready) begin
        y1[k] = data_out1; s1[k] = sat1;
        y0[k] = data_out0; s0[k] = sat0;
        k++;
      end
      step();
      n++;
    end
    m_ready = 1'b0;
    chk("drain_count", 32'(k), 32'(M));
  endtask

  task automatic chk_all(input string tag, input logic [T-1:0] e1 [M], input logic [T-1:0] e0 [M],
                         input logic [3:0] es1, input logic [3:0] es0);
    for (int i = 0; i < M; i++) begin
      chk($sformatf("%s_relu_y%0d", tag, i), 32'(y1[i]), 32'(e1[i]));
      chk($sformatf("%s_relu_sat%0d", tag, i), 32'(s1[i]), 32'(es1[i]));
      chk($sformatf("%s_lin_y%0d", tag, i), 32'(y0[i]), 32'(e0[i]));
      chk($sformatf("%s_lin_sat%0d", tag, i), 32'(s0[i]), 32'(es0[i]));
    end
  endtask

  initial begin
    logic [T-1:0] xa [N];
    logic [T-1:0] xm [N];
    logic [T-1:0] base [M];
    logic [T-1:0] e1 [M];
    logic [T-1:0] e0 [M];
    int n;

    reset = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0;
    s_valid = 1'b0; data_in = '0; m_ready = 1'b0;
    xa   = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    xm   = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    base = '{16'd15, 16'd16, 16'd17, 16'd18};

    // Reset values
    step(); step();
    chk("rst_s_ready", 32'(s_ready1), 32'd0);
    chk("rst_m_valid", 32'(m_valid1), 32'd0);
    chk("rst_data_out", 32'(data_out1), 32'd0);
    chk("rst_sat", 32'(sat1), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready1), 32'd1);
    reset = 1'b0;
    step();
    chk("post_rst_s_ready", 32'(s_ready1), 32'd1);

    // Basic: W all ones, b = {0,1,2,3}
    for (int a = 0; a < M*N; a++) cfg_wr(a, 16'd1);
    for (int i = 0; i < M; i++) cfg_wr(M*N + i, 16'(i));
    push_words(xa, N);
    drain(0);
    chk("latency", 32'(first_mv - acc_cyc), 32'(N + 4));
    chk_all("basic", base, base, 4'b0000, 4'b0000);

    // ReLU and sign: row0 = -1, b0 = -100 -> -115
    for (int j = 0; j < N; j++) cfg_wr(j, 16'hFFFF);
    cfg_wr(M*N, 16'hFF9C);
    push_words(xa, N);
    drain(0);
    e1 = '{16'd0, 16'd16, 16'd17, 16'd18};
    e0 = '{16'hFF8D, 16'd16, 16'd17, 16'd18};
    chk_all("relu", e1, e0, 4'b0000, 4'b0000);

    // Saturation: row1 = 32767, b1 = 0, x all 32767
    for (int j = 0; j < N; j++) cfg_wr(N + j, 16'h7FFF);
    cfg_wr(M*N + 1, 16'd0);
    push_words(xm, N);
    drain(0);
    e1 = '{16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    e0 = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    chk_all("sat_pos", e1, e0, 4'b1111, 4'b1111);

    // Saturation negative: row1 = -32768
    for (int j = 0; j < N; j++) cfg_wr(N + j, 16'h8000);
    push_words(xm, N);
    drain(0);
    e1 = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
    e0 = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
    chk_all("sat_neg", e1, e0, 4'b1111, 4'b1111);

    // Restore basic configuration for rows 0/1
    for (int a = 0; a < 2*N; a++) cfg_wr(a, 16'd1);
    cfg_wr(M*N, 16'd0);
    cfg_wr(M*N + 1, 16'd1);

    // Backpressure: hold m_ready low for 10 cycles at first m_valid
    push_words(xa, N);
    m_ready = 1'b0;
    n = 0;
    while (!m_valid1 && n < 50) begin step(); n++; end
    chk("bp_mvalid_seen", 32'(m_valid1), 32'd1);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold_data_%0d", c), 32'(data_out1), 32'd15);
      chk($sformatf("bp_hold_valid_%0d", c), 32'(m_valid1), 32'd1);
      chk($sformatf("bp_hold_sready_%0d", c), 32'(s_ready1), 32'd0);
      step();
    end
    drain(0);
    chk_all("bp", base, base, 4'b0000, 4'b0000);

    // Randomised m_ready
    push_words(xa, N);
    drain(1);
    chk_all("rand_rdy", base, base, 4'b0000, 4'b0000);

    // Reset mid-input: partial vector discarded, weights kept
    push_words(xa, 3);
    reset = 1'b1;
    step();
    chk("midrst_s_ready", 32'(s_ready1), 32'd0);
    chk("midrst_m_valid", 32'(m_valid1), 32'd0);
    reset = 1'b0;
    step();
    push_words(xa, N);
    drain(0);
    chk_all("midrst", base, base, 4'b0000, 4'b0000);

    // Config gating: write during COMPUTE is ignored
    push_words(xa, N);
    cfg_addr = 5'd0; cfg_data = 16'd50; cfg_wr_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("gate_cfg_ready_%0d", c), 32'(cfg_ready1), 32'd0);
      step();
    end
    cfg_wr_en = 1'b0;
    drain(0);
    chk_all("gate_busy", base, base, 4'b0000, 4'b0000);

    // Same write while idle takes effect
    cfg_wr(0, 16'd50);
    push_words(xa, N);
    drain(0);
    e1 = '{16'd64, 16'd16, 16'd17, 16'd18};
    chk_all("gate_idle", e1, e1, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
